gf467_accum_feed: RTL and testbench
===================================

GF467_ACCUM_FEED -- requirements
Module: gf467_accum_feed

Interface
REQ-001 SHALL have parameter Q, default 467, field modulus.
REQ-002 SHALL have parameter MAX_TERMS, default 256, terms per block before forced emit (Q-1)*MAX_TERMS < 2^17.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream term valid.
REQ-006 SHALL have port in_ready  output  1  block accepts term this cycle.
REQ-007 SHALL have port in_data  input  9  term, 0..511.
REQ-008 SHALL have port in_last  input  1  final term of current block.
REQ-009 SHALL have port out_valid  output  1  accumulated sum available to Barrett reducer.
REQ-010 SHALL have port out_ready  input  1  reducer accepts sum.
REQ-011 SHALL have port out_data  output  17  unreduced sum, drives reducer din_a.
REQ-012 SHALL have port out_count  output  9  number of terms in out_data, 1..MAX_TERMS.
REQ-013 SHALL have port out_forced  output  1  emit caused by MAX_TERMS, not in_last.

Function
REQ-014 SHALL accept a term when in_valid && in_ready (a "beat").
REQ-015 SHALL pre-reduce each term: term = in_data >= Q ? in_data - Q : in_data (511 -> 44).
REQ-016 SHALL implement states IDLE (acc=0, cnt=0), ACC (acc>0 terms), HOLD (output register full).
REQ-017 SHALL assert in_ready in IDLE and ACC; deassert in HOLD.
REQ-018 SHALL on a beat set acc <= acc + term and cnt <= cnt + 1 in the same edge.
REQ-019 SHALL on a beat with in_last, or with cnt+1 == MAX_TERMS, load out_data with acc+term, out_count with cnt+1, out_forced with !in_last, clear acc/cnt, go to HOLD.
REQ-020 SHALL assert out_valid the cycle after the closing beat (latency 1) and only in HOLD.
REQ-021 SHALL hold out_data/out_count/out_forced stable while out_valid && !out_ready.
REQ-022 SHALL on out_valid && out_ready leave HOLD for IDLE the next cycle; in_ready rises that cycle (one bubble per block).
REQ-023 SHALL treat in_last with cnt+1 == MAX_TERMS as a normal (out_forced=0) close.
REQ-024 SHALL keep acc 17 bits wide; overflow cannot occur given REQ-002 and REQ-015.
REQ-025 SHALL ignore in_data/in_last when no beat occurs.

Reset
REQ-026 SHALL on rst_n low, asynchronously: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_count=0, out_forced=0; in_ready=1 after release.
REQ-027 SHALL discard any partial block or held output on reset mid-operation; no emit follows.

Structure
REQ-028 SHALL place Q, MAX_TERMS defaults, data/count widths and the state enum in shared package gf467_pkg.
REQ-029 SHALL keep the datapath single-module; the conditional pre-reduce MAY be sub-module gf467_cond_sub, reused by the reducer output stage.

Verification
REQ-030 Beats 466, 466, 1(last), out_ready=1 -> out_data=933, out_count=3, out_forced=0, out_valid one cycle after beat 3.
REQ-031 Single beat 500(last) -> out_data=33, out_count=1.
REQ-032 256 beats of 466, in_last never set -> out_data=119296, out_count=256, out_forced=1; beat 257 starts new block.
REQ-033 Close block, hold out_ready=0 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; release -> in_ready=1 next cycle.
REQ-034 rst_n pulsed low after 10 beats, no in_last -> out_valid stays 0, next block 7(last) yields out_data=7, out_count=1.
REQ-035 Random streams fed through gf467_accum_feed and the 467 Barrett reducer -> dout_r equals (sum of terms) mod 467 for every block.

Source files
------------

// File: rtl/gf467_pkg.sv
// Shared constants and state encoding for the GF(467) accumulate-and-feed path.
package gf467_pkg;

  localparam int unsigned QDefault        = 467;
  localparam int unsigned MaxTermsDefault = 256;

  // Term, per-block count and unreduced sum widths.
  localparam int unsigned DataW = 9;
  localparam int unsigned CntW  = 9;
  localparam int unsigned AccW  = 17;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;  // acc and cnt are zero
  localparam state_t StAcc  = 2'd1;  // at least one term accumulated
  localparam state_t StHold = 2'd2;  // output register full, waiting on reducer

endpackage

// File: rtl/gf467_cond_sub.sv
// Conditional subtract: folds a value in [0, 2*Q) down to [0, Q).
module gf467_cond_sub #(
  parameter int unsigned Q     = 467,
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  // Single subtract is enough because 2^Width <= 2*Q for the intended use.
  always_comb begin
    dout_o = din_i;
    if (din_i >= Width'(Q)) begin
      dout_o = din_i - Width'(Q);
    end
  end

endmodule

// File: rtl/gf467_accum_feed.sv
// Accumulates pre-reduced GF(467) terms into blocks and hands each unreduced block
// sum to the downstream Barrett reducer through a one-entry output register.
module gf467_accum_feed
  import gf467_pkg::*;
#(
  parameter int unsigned Q         = QDefault,
  parameter int unsigned MAX_TERMS = MaxTermsDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DataW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AccW-1:0] out_data,
  output logic [CntW-1:0] out_count,
  output logic            out_forced
);

  state_t          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] out_data_q, out_data_d;
  logic [CntW-1:0] out_count_q, out_count_d;
  logic            out_forced_q, out_forced_d;

  logic [DataW-1:0] term;
  logic [AccW-1:0]  acc_sum;
  logic [CntW-1:0]  cnt_inc;
  logic             beat;
  logic             close;

  gf467_cond_sub #(
    .Q     (Q),
    .Width (DataW)
  ) u_pre_reduce (
    .din_i  (in_data),
    .dout_o (term)
  );

  assign in_ready   = (state_q != StHold);
  assign out_valid  = (state_q == StHold);
  assign out_data   = out_data_q;
  assign out_count  = out_count_q;
  assign out_forced = out_forced_q;

  assign beat    = in_valid && in_ready;
  assign acc_sum = acc_q + AccW'(term);
  assign cnt_inc = cnt_q + CntW'(1);
  // A term that is both last and the MAX_TERMS-th is treated as a normal close.
  assign close   = in_last || (cnt_inc == CntW'(MAX_TERMS));

  // Next-state: accumulate on beats, load the output register on block close.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_forced_d = out_forced_q;
    case (state_q)
      StIdle, StAcc: begin
        if (beat) begin
          if (close) begin
            out_data_d   = acc_sum;
            out_count_d  = cnt_inc;
            out_forced_d = !in_last;
            acc_d        = '0;
            cnt_d        = '0;
            state_d      = StHold;
          end else begin
            acc_d   = acc_sum;
            cnt_d   = cnt_inc;
            state_d = StAcc;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial block or held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_forced_q <= out_forced_d;
    end
  end

endmodule

// File: tb/tb_gf467_accum_feed.sv
// Scoreboard bench for gf467_accum_feed: the driver predicts block results from a
// plain arithmetic model, the monitor pops and compares on every output handshake.
module tb_gf467_accum_feed;

  localparam int QMod = 467;
  localparam int MaxT = 256;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [8:0]  out_count;
  logic        out_forced;

  gf467_accum_feed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_forced (out_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int count;
    int forced;
    int rmod;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: running block contents.
  int m_sum = 0;
  int m_cnt = 0;
  int m_raw = 0;

  // 0: out_ready low, 1: high, 2: random each cycle
  int ready_mode = 1;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_flush();
    m_sum = 0;
    m_cnt = 0;
    m_raw = 0;
  endtask

  // One term offered until accepted; model updated on the accepting edge.
  task automatic send(input int d, input bit last);
    int  tries;
    bit  closed;
    exp_t e;
    tries  = 0;
    closed = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9'(d);
      in_last  = last;
      #1;
      if (in_ready) break;
      tries++;
      if (tries > 2000) begin
        chk("send_timeout", tries, 0);
        in_valid = 1'b0;
        return;
      end
    end
    m_sum += (d >= QMod) ? d - QMod : d;
    m_raw  = (m_raw + d) % QMod;
    m_cnt++;
    if (last || m_cnt == MaxT) begin
      e.data   = m_sum;
      e.count  = m_cnt;
      e.forced = last ? 0 : 1;
      e.rmod   = m_raw;
      sb.push_back(e);
      model_flush();
      closed = 1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (closed) begin
      chk("latency_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
  endtask

  // Idle cycles with junk on the data lines that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 9'($urandom_range(0, 511));
      in_last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", int'(n < 3000), 1);
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: stability while stalled, and scoreboard compare on each handshake.
  initial begin
    bit   hold_prev;
    int   p_data;
    int   p_count;
    int   p_forced;
    exp_t e;
    hold_prev = 0;
    p_data = 0;
    p_count = 0;
    p_forced = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_data", int'(out_data), p_data);
          chk("stall_count", int'(out_count), p_count);
          chk("stall_forced", int'(out_forced), p_forced);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_emit: got data=%0d count=%0d, required no output",
                     out_data, out_count);
          end else begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), e.data);
            chk("out_count", int'(out_count), e.count);
            chk("out_forced", int'(out_forced), e.forced);
            chk("reduced_mod_q", int'(out_data) % QMod, e.rmod);
          end
        end
        hold_prev = out_valid && !out_ready;
        p_data    = int'(out_data);
        p_count   = int'(out_count);
        p_forced  = int'(out_forced);
      end
    end
  end

  initial begin
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_forced", int'(out_forced), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    // 466 + 466 + 1 = 933
    ready_mode = 1;
    send(466, 0);
    send(466, 0);
    send(1, 1);
    wait_drain();

    // 500 pre-reduces to 33
    send(500, 1);
    wait_drain();

    // Forced emit at MAX_TERMS, then the next beat opens a fresh block.
    for (int i = 0; i < MaxT; i++) send(466, 0);
    send(5, 1);
    wait_drain();

    // Reducer stall: outputs frozen and input blocked; one bubble after release.
    ready_mode = 0;
    send(100, 0);
    send(200, 1);
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("stall5_out_valid", int'(out_valid), 1);
      chk("stall5_in_ready", int'(in_ready), 0);
    end
    ready_mode = 1;
    @(negedge clk);
    #2;
    @(posedge clk);
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    wait_drain();

    // Reset mid-block discards the partial sum.
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 511)), 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_flush();
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("postrst_no_emit", int'(out_valid), 0);
    end
    send(7, 1);
    wait_drain();

    // Random blocks, random gaps, random reducer back-pressure.
    ready_mode = 2;
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) send(int'($urandom_range(QMod, 511)), i == len - 1);
        else send(int'($urandom_range(0, 511)), i == len - 1);
      end
    end
    ready_mode = 1;
    wait_drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
